// File: rtl/traffic_safety_monitor_if.sv
// Lamp-vector bundle between the traffic controller, the safety monitor and the lamp drivers.
// Latency: none, wires only.
// Backpressure: none; lamp vectors are sampled every cycle.
interface traffic_safety_monitor_if;
  logic [2:0] led_in1;
  logic [2:0] led_in2;
  logic       fault_clr;
  logic [2:0] led_out1;
  logic [2:0] led_out2;
  logic       fault;
  logic [2:0] fault_code;

  // Controller / test side: drives lamp requests and the clear, observes driver outputs.
  modport master (
    output led_in1, led_in2, fault_clr,
    input  led_out1, led_out2, fault, fault_code
  );

  // Monitor side.
  modport slave (
    input  led_in1, led_in2, fault_clr,
    output led_out1, led_out2, fault, fault_code
  );
endinterface

// File: rtl/traffic_safety_monitor.sv
// Safety gate between traffic controller and lamp drivers; latches a fault and flashes yellow.
// Latency: one cycle input to led_out in PASS; fault and flashing appear one edge after a violation.
// Backpressure: none; every cycle is a sample, and a fault holds until an accepted fault_clr.
module traffic_safety_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_STUCK  = 1000,
  parameter int FLASH_DIV  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  traffic_safety_monitor_if.slave io_bus
);

  localparam int DW = $clog2(MAX_STUCK + 2);
  localparam int FW = (FLASH_DIV > 1) ? $clog2(2 * FLASH_DIV) : 1;

  localparam logic [DW-1:0] C_STUCK = DW'(MAX_STUCK);
  localparam logic [DW-1:0] C_SAT   = DW'(MAX_STUCK + 1);
  localparam logic [DW-1:0] C_MINY  = DW'(MIN_YELLOW);
  localparam logic [FW-1:0] C_FLAST = FW'(2 * FLASH_DIV - 1);
  localparam logic [FW-1:0] C_FDIV  = FW'(FLASH_DIV);

  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  typedef enum logic {S_PASS, S_FAULT} state_t;

  state_t          r_state;
  logic [2:0]      r_out1, r_out2;
  logic            r_fault;
  logic [2:0]      r_code;
  logic [2:0]      r_prev1, r_prev2;
  logic            r_prev_vld;
  logic [DW-1:0]   r_dwell1, r_dwell2;
  logic [FW-1:0]   r_flash;

  logic            w_inv, w_conf;
  logic [2:0]      w_seq1, w_seq2, w_code;
  logic [FW-1:0]   w_flash_nxt;

  function automatic logic f_onehot(input logic [2:0] v);
    return (v == L_R) || (v == L_Y) || (v == L_G);
  endfunction

  function automatic logic f_legal(input logic [2:0] p, input logic [2:0] v);
    return (p == L_R && v == L_G) || (p == L_G && v == L_Y) || (p == L_Y && v == L_R);
  endfunction

  // History-dependent checks for one approach; invalid vectors are already caught as code 1.
  function automatic logic [2:0] f_seq_code(input logic [2:0] v, input logic [2:0] p,
                                            input logic pv, input logic [DW-1:0] d);
    if (!pv)                                    return 3'd0;
    if (v != p && !f_legal(p, v))               return 3'd3;
    if (p == L_Y && v == L_R && d < C_MINY)     return 3'd4;
    if (v == p && d == C_STUCK)                 return 3'd5;
    return 3'd0;
  endfunction

  function automatic logic [DW-1:0] f_dwell_nxt(input logic [2:0] v, input logic [2:0] p,
                                                input logic pv, input logic [DW-1:0] d);
    if (!pv || v != p) return DW'(1);
    if (d == C_SAT)    return d;
    return d + 1'b1;
  endfunction

  // Violation detection on the current inputs, lowest code wins.
  always_comb begin
    w_inv  = !f_onehot(io_bus.led_in1) || !f_onehot(io_bus.led_in2);
    w_conf = !io_bus.led_in1[2] && !io_bus.led_in2[2];
    w_seq1 = f_seq_code(io_bus.led_in1, r_prev1, r_prev_vld, r_dwell1);
    w_seq2 = f_seq_code(io_bus.led_in2, r_prev2, r_prev_vld, r_dwell2);
    w_code = 3'd0;
    if (w_inv)
      w_code = 3'd1;
    else if (w_conf)
      w_code = 3'd2;
    else if (w_seq1 != 3'd0 && (w_seq2 == 3'd0 || w_seq1 <= w_seq2))
      w_code = w_seq1;
    else
      w_code = w_seq2;
    w_flash_nxt = (r_flash == C_FLAST) ? '0 : r_flash + 1'b1;
  end

  // PASS/FAULT state machine with registered lamp outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_PASS;
      r_out1     <= L_R;
      r_out2     <= L_R;
      r_fault    <= 1'b0;
      r_code     <= 3'd0;
      r_prev1    <= L_OFF;
      r_prev2    <= L_OFF;
      r_prev_vld <= 1'b0;
      r_dwell1   <= '0;
      r_dwell2   <= '0;
      r_flash    <= '0;
    end else begin
      case (r_state)
        S_PASS: begin
          if (w_code != 3'd0) begin
            // Offending vector is never forwarded; flashing starts in phase A.
            r_state <= S_FAULT;
            r_fault <= 1'b1;
            r_code  <= w_code;
            r_flash <= '0;
            r_out1  <= L_Y;
            r_out2  <= L_Y;
          end else begin
            r_out1     <= io_bus.led_in1;
            r_out2     <= io_bus.led_in2;
            r_prev1    <= io_bus.led_in1;
            r_prev2    <= io_bus.led_in2;
            r_prev_vld <= 1'b1;
            r_dwell1   <= f_dwell_nxt(io_bus.led_in1, r_prev1, r_prev_vld, r_dwell1);
            r_dwell2   <= f_dwell_nxt(io_bus.led_in2, r_prev2, r_prev_vld, r_dwell2);
          end
        end
        S_FAULT: begin
          r_flash <= w_flash_nxt;
          r_out1  <= (w_flash_nxt < C_FDIV) ? L_Y : L_OFF;
          r_out2  <= (w_flash_nxt < C_FDIV) ? L_Y : L_OFF;
          // Clear is honoured only when the lamps being requested are sane.
          if (io_bus.fault_clr && !w_inv && !w_conf) begin
            r_state    <= S_PASS;
            r_fault    <= 1'b0;
            r_code     <= 3'd0;
            r_prev_vld <= 1'b0;
            r_dwell1   <= '0;
            r_dwell2   <= '0;
          end
        end
        default: r_state <= S_PASS;
      endcase
    end
  end

  assign io_bus.led_out1   = r_out1;
  assign io_bus.led_out2   = r_out2;
  assign io_bus.fault      = r_fault;
  assign io_bus.fault_code = r_code;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Scoreboard bench for traffic_safety_monitor: history-based reference model plus a monitor.
// Latency modelled: expected outputs after each rising edge are queued at that edge.
// Backpressure: none; one expected item per clock edge.
module tb_traffic_safety_monitor;

  localparam int MIN_Y  = 3;
  localparam int MAX_ST = 10;
  localparam int FDIV   = 4;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct packed {
    logic [2:0] o1;
    logic [2:0] o2;
    logic       f;
    logic [2:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  traffic_safety_monitor_if bus();

  traffic_safety_monitor #(.MIN_YELLOW(MIN_Y), .MAX_STUCK(MAX_ST), .FLASH_DIV(FDIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  // Model state: full lamp history since the last reset/clear, fault flag, cycles in fault.
  logic [2:0] h1[$];
  logic [2:0] h2[$];
  logic       m_fault = 1'b0;
  logic [2:0] m_code  = 3'd0;
  int         m_k     = 0;

  function automatic bit onehot(input logic [2:0] v);
    return v == R || v == Y || v == G;
  endfunction

  // Length of the trailing run of identical samples in a history.
  function automatic int run_len(input logic [2:0] h[$]);
    int n = 0;
    for (int i = h.size() - 1; i >= 0; i--) begin
      if (h[i] != h[h.size()-1] || n > MAX_ST) break;
      n++;
    end
    return n;
  endfunction

  function automatic int appr_code(input logic [2:0] v, input logic [2:0] h[$]);
    logic [2:0] last;
    int run;
    if (h.size() == 0) return 0;
    last = h[h.size()-1];
    run  = run_len(h);
    if (v != last && !((last == R && v == G) || (last == G && v == Y) || (last == Y && v == R)))
      return 3;
    if (last == Y && v == R && run < MIN_Y) return 4;
    if (v == last && run == MAX_ST) return 5;
    return 0;
  endfunction

  // Reference model: evaluates each edge and queues the expected post-edge outputs.
  always @(posedge clk) begin
    exp_t e;
    logic [2:0] a, b;
    int c1, c2, c;
    a = bus.led_in1;
    b = bus.led_in2;
    if (rst) begin
      h1.delete(); h2.delete();
      m_fault = 1'b0; m_code = 3'd0; m_k = 0;
      e = '{o1: R, o2: R, f: 1'b0, code: 3'd0};
    end else if (!m_fault) begin
      c1 = appr_code(a, h1);
      c2 = appr_code(b, h2);
      if (!onehot(a) || !onehot(b))      c = 1;
      else if (!a[2] && !b[2])           c = 2;
      else if (c1 == 0)                  c = c2;
      else if (c2 == 0)                  c = c1;
      else                               c = (c1 < c2) ? c1 : c2;
      if (c == 0) begin
        h1.push_back(a); h2.push_back(b);
        e = '{o1: a, o2: b, f: 1'b0, code: 3'd0};
      end else begin
        m_fault = 1'b1; m_code = 3'(c); m_k = 1;
        e = '{o1: Y, o2: Y, f: 1'b1, code: m_code};
      end
    end else begin
      m_k++;
      e.o1 = (((m_k - 1) / FDIV) % 2 == 0) ? Y : 3'b000;
      e.o2 = e.o1;
      if (bus.fault_clr && onehot(a) && onehot(b) && (a[2] || b[2])) begin
        m_fault = 1'b0; m_code = 3'd0;
        h1.delete(); h2.delete();
      end
      e.f    = m_fault;
      e.code = m_code;
    end
    sb_q.push_back(e);
  end

  task automatic cmp3(input string name, input logic [2:0] act, input logic [2:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, want);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp3("led_out1",   bus.led_out1,   e.o1);
      cmp3("led_out2",   bus.led_out2,   e.o2);
      cmp3("fault",      {2'b00, bus.fault}, {2'b00, e.f});
      cmp3("fault_code", bus.fault_code, e.code);
    end
  end

  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic clr);
    @(negedge clk);
    bus.led_in1   = a;
    bus.led_in2   = b;
    bus.fault_clr = clr;
  endtask

  task automatic hold(input logic [2:0] a, input logic [2:0] b, input logic clr, input int n);
    for (int i = 0; i < n; i++) step(a, b, clr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] w1;
    logic [2:0] a, b;
    logic clr;
    bus.led_in1 = 3'($urandom);
    bus.led_in2 = 3'($urandom);
    bus.fault_clr = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) step(3'($urandom), 3'($urandom), 1'($urandom));

    // Legal cycle on approach 1.
    @(negedge clk);
    rst = 1'b0;
    bus.led_in1 = R; bus.led_in2 = R; bus.fault_clr = 1'b0;
    hold(R, R, 0, 1);
    hold(G, R, 0, 5);
    hold(Y, R, 0, 3);
    hold(R, R, 0, 2);

    // Conflict, full flash period, then refused and accepted clears.
    hold(G, G, 0, 1);
    hold(R, R, 0, 9);
    hold(G, G, 1, 1);
    hold(R, G, 1, 1);
    hold(R, G, 0, 1);
    hold(R, Y, 0, 3);
    hold(R, R, 0, 1);

    // Short yellow on approach 1.
    hold(G, R, 0, 1);
    hold(Y, R, 0, 2);
    hold(R, R, 0, 2);
    hold(R, R, 1, 1);

    // Invalid beats conflict.
    hold(R, R, 0, 1);
    hold(3'b011, G, 0, 1);
    hold(R, R, 1, 1);

    // Stuck green, then direct G->R.
    hold(G, R, 0, 12);
    hold(R, R, 1, 1);
    hold(G, R, 0, 1);
    hold(R, R, 0, 2);

    // Reset during phase A must take effect immediately.
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp3("rst_async_out1",  bus.led_out1,   R);
    cmp3("rst_async_out2",  bus.led_out2,   R);
    cmp3("rst_async_fault", {2'b00, bus.fault}, 3'b000);
    cmp3("rst_async_code",  bus.fault_code, 3'd0);
    hold(R, R, 0, 1);
    rst = 1'b0;

    // Randomized traffic: legal walker with corruption, random clears and rare resets.
    w1 = R;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0)
        w1 = (w1 == R) ? G : (w1 == G) ? Y : R;
      a = w1;
      b = R;
      if ($urandom_range(0, 99) < 4) a = 3'($urandom);
      if ($urandom_range(0, 99) < 3) b = 3'($urandom);
      clr = ($urandom_range(0, 5) == 0);
      step(a, b, clr);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        step(a, b, 0);
        rst = 1'b0;
      end
    end

    hold(R, R, 0, 3);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
